// File: rtl/layer_buf_pkg.sv
`default_nettype none
// ============================================================================
// Module   : layer_buf_pkg
// Purpose  : Shared constants, types and the signed narrowing helper used by
//            the inter-layer activation buffer (layer_buf_ram).
// Contents : c_DEPTH / c_BURST / c_WIDTH / c_OUT_WIDTH default sizes,
//            acc_t (stored accumulator word), act_t (narrowed activation),
//            sat_narrow() signed saturation of acc_t into act_t.
// Revision : 1.0 - initial release
// ============================================================================
package layer_buf_pkg;

    localparam int c_DEPTH     = 64;
    localparam int c_BURST     = 16;
    localparam int c_WIDTH     = 36;
    localparam int c_OUT_WIDTH = 18;

    typedef logic signed [c_WIDTH-1:0]     acc_t;
    typedef logic signed [c_OUT_WIDTH-1:0] act_t;

    localparam act_t c_ACT_MAX = {1'b0, {(c_OUT_WIDTH-1){1'b1}}};
    localparam act_t c_ACT_MIN = {1'b1, {(c_OUT_WIDTH-1){1'b0}}};

    // The value fits when every bit from the sign bit down to the narrowed
    // sign position agrees; otherwise clamp towards the sign of the input.
    function automatic act_t sat_narrow(input acc_t a);
        logic [c_WIDTH-c_OUT_WIDTH:0] hi;
        hi = a[c_WIDTH-1:c_OUT_WIDTH-1];
        if ((&hi) || (~|hi)) begin
            return a[c_OUT_WIDTH-1:0];
        end else if (a[c_WIDTH-1]) begin
            return c_ACT_MIN;
        end else begin
            return c_ACT_MAX;
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/layer_buf_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : layer_buf_ctrl
// Purpose  : Write-side control for layer_buf_ram: burst accept, BURST-aligned
//            write pointer, frame-full hold and frame_done pulse.
// Ports    : clk, rst_n (sync, active-low)
//            wr_valid   in  - burst offered
//            frame_ack  in  - consumer releases a held frame
//            wr_ready   out - !full
//            full       out - frame complete and held
//            frame_done out - one-cycle pulse when full rises
//            wr_ptr     out - current write base address
//            wr_en      out - write strobe to the storage array
//            wr_base    out - base address for the strobed burst
// Revision : 1.0 - initial release
// ============================================================================
module layer_buf_ctrl
    import layer_buf_pkg::*;
#(
    parameter int DEPTH = c_DEPTH,
    parameter int BURST = c_BURST,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_valid,
    input  logic             frame_ack,
    output logic             wr_ready,
    output logic             full,
    output logic             frame_done,
    output logic [PTR_W-1:0] wr_ptr,
    output logic             wr_en,
    output logic [PTR_W-1:0] wr_base
);

    localparam logic [PTR_W-1:0] c_LAST_BASE = PTR_W'(DEPTH - BURST);
    localparam logic [PTR_W-1:0] c_STEP      = PTR_W'(BURST);

    logic [PTR_W-1:0] r_wr_ptr_q, w_wr_ptr_d;
    logic             r_full_q, w_full_d;
    logic             r_frame_done_q, w_frame_done_d;
    logic             w_accept;

    // An ack arriving with the last-burst accept is dropped on purpose:
    // full is still low in that cycle, so the release branch is not taken.
    always_comb begin
        w_accept       = wr_valid && !r_full_q;
        w_wr_ptr_d     = r_wr_ptr_q;
        w_full_d       = r_full_q;
        w_frame_done_d = 1'b0;
        if (w_accept) begin
            // Power-of-two DEPTH: the PTR_W-bit add wraps to 0 after the last burst
            w_wr_ptr_d = r_wr_ptr_q + c_STEP;
            if (r_wr_ptr_q == c_LAST_BASE) begin
                w_full_d       = 1'b1;
                w_frame_done_d = 1'b1;
            end
        end else if (r_full_q && frame_ack) begin
            w_full_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr_q     <= '0;
            r_full_q       <= 1'b0;
            r_frame_done_q <= 1'b0;
        end else begin
            r_wr_ptr_q     <= w_wr_ptr_d;
            r_full_q       <= w_full_d;
            r_frame_done_q <= w_frame_done_d;
        end
    end

    assign wr_ready   = !r_full_q;
    assign full       = r_full_q;
    assign frame_done = r_frame_done_q;
    assign wr_ptr     = r_wr_ptr_q;
    assign wr_en      = w_accept;
    assign wr_base    = r_wr_ptr_q;

endmodule
`default_nettype wire

// File: rtl/layer_buf_ram.sv
`default_nettype none
// ============================================================================
// Module   : layer_buf_ram
// Purpose  : Inter-layer activation buffer. Bursts of BURST words are written
//            at an auto-incrementing pointer; the whole buffer is exposed in
//            parallel (narrowed to OUT_WIDTH) and a full frame is held until
//            frame_ack.
// Ports    : clk, rst_n (sync, active-low)
//            wr_valid/wr_ready  burst handshake, wr_data[BURST][WIDTH]
//            frame_ack          release held frame
//            full, frame_done   frame status / one-cycle completion pulse
//            wr_ptr             write base address
//            dout[DEPTH][OUT_WIDTH]  all stored words, narrowed
//            dout_wr[BURST][WIDTH]   full-width words at wr_ptr..+BURST-1
// Config   : LAYER_BUF_SAT_EN - when defined, dout saturates (signed) instead
//            of truncating. dout_wr is full width in both builds.
// Revision : 1.0 - initial release
// ============================================================================
module layer_buf_ram
    import layer_buf_pkg::*;
#(
    parameter int DEPTH     = c_DEPTH,
    parameter int BURST     = c_BURST,
    parameter int WIDTH     = c_WIDTH,
    parameter int OUT_WIDTH = c_OUT_WIDTH,
    parameter int PTR_W     = $clog2(DEPTH)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            wr_valid,
    output logic                            wr_ready,
    input  logic [BURST-1:0][WIDTH-1:0]     wr_data,
    input  logic                            frame_ack,
    output logic                            full,
    output logic                            frame_done,
    output logic [PTR_W-1:0]                wr_ptr,
    output logic [DEPTH-1:0][OUT_WIDTH-1:0] dout,
    output logic [BURST-1:0][WIDTH-1:0]     dout_wr
);

    logic                        w_wr_en;
    logic [PTR_W-1:0]            w_wr_base;
    logic [DEPTH-1:0][WIDTH-1:0] r_mem_q, w_mem_d;

    layer_buf_ctrl #(
        .DEPTH (DEPTH),
        .BURST (BURST),
        .PTR_W (PTR_W)
    ) u_ctrl (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_valid   (wr_valid),
        .frame_ack  (frame_ack),
        .wr_ready   (wr_ready),
        .full       (full),
        .frame_done (frame_done),
        .wr_ptr     (wr_ptr),
        .wr_en      (w_wr_en),
        .wr_base    (w_wr_base)
    );

    always_comb begin
        w_mem_d = r_mem_q;
        if (w_wr_en) begin
            for (int k = 0; k < BURST; k++) begin
                w_mem_d[w_wr_base + PTR_W'(k)] = wr_data[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mem_q <= '0;
        end else begin
            r_mem_q <= w_mem_d;
        end
    end

    for (genvar j = 0; j < BURST; j++) begin : g_dout_wr
        assign dout_wr[j] = r_mem_q[wr_ptr + PTR_W'(j)];
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_dout
`ifdef LAYER_BUF_SAT_EN
        if (WIDTH == c_WIDTH && OUT_WIDTH == c_OUT_WIDTH) begin : g_sat_pkg
            assign dout[i] = sat_narrow(r_mem_q[i]);
        end else begin : g_sat_gen
            // Same clamp as sat_narrow, written for arbitrary widths
            logic [WIDTH-OUT_WIDTH:0] w_hi;
            assign w_hi    = r_mem_q[i][WIDTH-1:OUT_WIDTH-1];
            assign dout[i] = ((&w_hi) || (~|w_hi)) ? r_mem_q[i][OUT_WIDTH-1:0] :
                             r_mem_q[i][WIDTH-1]   ? {1'b1, {(OUT_WIDTH-1){1'b0}}} :
                                                     {1'b0, {(OUT_WIDTH-1){1'b1}}};
        end
`else
        assign dout[i] = r_mem_q[i][OUT_WIDTH-1:0];
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_layer_buf_ram.sv
`default_nettype none
// ============================================================================
// Module   : tb_layer_buf_ram
// Purpose  : Directed self-checking bench for layer_buf_ram (default sizes:
//            DEPTH=64, BURST=16, WIDTH=36, OUT_WIDTH=18). Honours
//            LAYER_BUF_SAT_EN for the expected narrowing of dout.
// Revision : 1.0 - initial release
// ============================================================================
module tb_layer_buf_ram;

    localparam int DEPTH = 64;
    localparam int BURST = 16;
    localparam int WIDTH = 36;
    localparam int OW    = 18;
    localparam int PW    = 6;

    logic                        clk = 1'b0;
    logic                        rst_n = 1'b0;
    logic                        wr_valid = 1'b0;
    logic                        frame_ack = 1'b0;
    logic [BURST-1:0][WIDTH-1:0] wr_data = '0;
    logic                        wr_ready, full, frame_done;
    logic [PW-1:0]               wr_ptr;
    logic [DEPTH-1:0][OW-1:0]    dout;
    logic [BURST-1:0][WIDTH-1:0] dout_wr;

    int errors = 0;
    int checks = 0;

    logic [WIDTH-1:0] exp_mem [DEPTH];
    int               exp_ptr;
    bit               exp_full;

    always #5 clk = ~clk;

    layer_buf_ram dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_data    (wr_data),
        .frame_ack  (frame_ack),
        .full       (full),
        .frame_done (frame_done),
        .wr_ptr     (wr_ptr),
        .dout       (dout),
        .dout_wr    (dout_wr)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [OW-1:0] narrow(input logic [WIDTH-1:0] v);
`ifdef LAYER_BUF_SAT_EN
        if ($signed(v) > 36'sd131071)       return 18'h1FFFF;
        else if ($signed(v) < -36'sd131072) return 18'h20000;
        else                                return v[OW-1:0];
`else
        return v[OW-1:0];
`endif
    endfunction

    task automatic chk_mem(input string tag);
        for (int i = 0; i < DEPTH; i++)
            chk($sformatf("%s dout[%0d]", tag, i), 64'(dout[i]), 64'(narrow(exp_mem[i])));
    endtask

    task automatic chk_wr(input string tag);
        for (int j = 0; j < BURST; j++)
            chk($sformatf("%s dout_wr[%0d]", tag, j), 64'(dout_wr[j]),
                64'(exp_mem[(exp_ptr + j) % DEPTH]));
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
        exp_ptr  = 0;
        exp_full = 1'b0;
    endtask

    // Called at a negedge: offers wr_data for one rising edge, returns at the next negedge.
    task automatic send(input bit ack);
        wr_valid  = 1'b1;
        frame_ack = ack;
        if (!exp_full) begin
            for (int k = 0; k < BURST; k++) exp_mem[(exp_ptr + k) % DEPTH] = wr_data[k];
            if (exp_ptr == DEPTH - BURST) exp_full = 1'b1;
            exp_ptr = (exp_ptr + BURST) % DEPTH;
        end else if (ack) begin
            exp_full = 1'b0;
        end
        @(negedge clk);
        wr_valid  = 1'b0;
        frame_ack = 1'b0;
    endtask

    task automatic fill_addr(input int base);
        for (int k = 0; k < BURST; k++) wr_data[k] = WIDTH'(base + k);
    endtask

    task automatic ack_once();
        frame_ack = 1'b1;
        if (exp_full) exp_full = 1'b0;
        @(negedge clk);
        frame_ack = 1'b0;
    endtask

    initial begin
        model_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset / idle state
        chk("rst wr_ptr", 64'(wr_ptr), 64'd0);
        chk("rst full", 64'(full), 64'd0);
        chk("rst wr_ready", 64'(wr_ready), 64'd1);
        chk("rst frame_done", 64'(frame_done), 64'd0);
        chk_mem("rst");
        chk_wr("rst");

        // Four back-to-back bursts, data = address
        for (int b = 0; b < 4; b++) begin
            fill_addr(b * BURST);
            send(1'b0);
            chk($sformatf("f1 wr_ptr b%0d", b), 64'(wr_ptr), 64'(((b + 1) * 16) % 64));
            chk($sformatf("f1 frame_done b%0d", b), 64'(frame_done), 64'(b == 3));
            chk($sformatf("f1 full b%0d", b), 64'(full), 64'(b == 3));
        end
        chk("f1 dout[37]", 64'(dout[37]), 64'd37);
        chk("f1 dout[63]", 64'(dout[63]), 64'd63);
        chk_mem("f1");
        @(negedge clk);
        chk("f1 frame_done drop", 64'(frame_done), 64'd0);
        chk("f1 full hold", 64'(full), 64'd1);

        // Offers while full are ignored
        for (int k = 0; k < BURST; k++) wr_data[k] = 36'hFFFF;
        chk("held wr_ready", 64'(wr_ready), 64'd0);
        send(1'b0);
        chk("held wr_ptr", 64'(wr_ptr), 64'd0);
        chk("held full", 64'(full), 64'd1);
        chk("held dout[5]", 64'(dout[5]), 64'd5);
        chk_mem("held");

        // Release, then one burst of 5 overwrites only the first 16 words
        ack_once();
        chk("ack full", 64'(full), 64'd0);
        chk("ack wr_ready", 64'(wr_ready), 64'd1);
        for (int k = 0; k < BURST; k++) wr_data[k] = 36'h5;
        send(1'b0);
        chk("p5 wr_ptr", 64'(wr_ptr), 64'd16);
        chk("p5 dout[0]", 64'(dout[0]), 64'd5);
        chk("p5 dout[15]", 64'(dout[15]), 64'd5);
        chk("p5 dout[16]", 64'(dout[16]), 64'd16);
        chk("p5 dout_wr[3]", 64'(dout_wr[3]), 64'd19);
        chk_mem("p5");
        chk_wr("p5");

        // Ack coincident with the last-burst accept is lost
        for (int b = 1; b < 4; b++) begin
            fill_addr(b * BURST);
            send(b == 3);
        end
        chk("lost-ack full", 64'(full), 64'd1);
        chk("lost-ack frame_done", 64'(frame_done), 64'd1);
        chk("lost-ack wr_ptr", 64'(wr_ptr), 64'd0);
        @(negedge clk);
        chk("lost-ack full stays", 64'(full), 64'd1);
        ack_once();
        chk("re-ack full", 64'(full), 64'd0);

        // Narrowing of out-of-range and in-range signed values
        wr_data    = '0;
        wr_data[0] = 36'h0_0004_0001;
        wr_data[1] = 36'hF_FFF0_0000;
        wr_data[2] = 36'hF_FFFF_FFFD;
        wr_data[3] = 36'h0_0001_FFFF;
        send(1'b0);
`ifdef LAYER_BUF_SAT_EN
        chk("sat dout[0]", 64'(dout[0]), 64'h1FFFF);
        chk("sat dout[1]", 64'(dout[1]), 64'h20000);
`else
        chk("sat dout[0]", 64'(dout[0]), 64'h00001);
        chk("sat dout[1]", 64'(dout[1]), 64'h00000);
`endif
        chk("sat dout[2]", 64'(dout[2]), 64'h3FFFD);
        chk("sat dout[3]", 64'(dout[3]), 64'h1FFFF);
        wr_data = '0;
        for (int b = 1; b < 4; b++) send(1'b0);
        chk("sat full", 64'(full), 64'd1);
        chk("sat dout_wr[0]", 64'(dout_wr[0]), 64'h0_0004_0001);
        chk("sat dout_wr[1]", 64'(dout_wr[1]), 64'hF_FFF0_0000);
        chk_mem("sat");
        chk_wr("sat");
        ack_once();

        // Reset mid-frame overrides a concurrent offer
        for (int k = 0; k < BURST; k++) wr_data[k] = 36'h7;
        send(1'b0);
        send(1'b0);
        chk("mid wr_ptr", 64'(wr_ptr), 64'd32);
        rst_n    = 1'b0;
        wr_valid = 1'b1;
        @(negedge clk);
        rst_n    = 1'b1;
        wr_valid = 1'b0;
        model_reset();
        chk("mrst wr_ptr", 64'(wr_ptr), 64'd0);
        chk("mrst full", 64'(full), 64'd0);
        chk("mrst frame_done", 64'(frame_done), 64'd0);
        chk("mrst wr_ready", 64'(wr_ready), 64'd1);
        chk_mem("mrst");
        chk_wr("mrst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/layer_buf_ram.md
Name: layer_buf_ram

Overview:
- Parametrised inter-layer activation buffer for the CNN pipeline.
- Accepts bursts of BURST words through a valid/ready handshake and writes them at an auto-incrementing pointer.
- Exposes the whole buffer in parallel, narrowed to OUT_WIDTH, to the next layer.
- Holds a completed frame (full) until the consumer releases it with frame_ack.

Parameters:
- DEPTH, 64, number of stored words; must be a multiple of BURST.
- BURST, 16, words written per accepted transfer.
- WIDTH, 36, stored word width (signed accumulator result).
- OUT_WIDTH, 18, width of each dout word; OUT_WIDTH <= WIDTH.
- PTR_W, $clog2(DEPTH), write pointer width (derived).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- wr_valid  in  1  burst offered on wr_data.
- wr_ready  out  1  buffer can accept a burst this cycle.
- wr_data  in  [WIDTH-1:0] x BURST  burst words; lane k goes to address ptr+k.
- frame_ack  in  1  consumer releases the full frame.
- full  out  1  DEPTH words written, frame held.
- frame_done  out  1  one-cycle pulse on the cycle full rises.
- wr_ptr  out  PTR_W  current write base address.
- dout  out  [OUT_WIDTH-1:0] x DEPTH  all words, narrowed.
- dout_wr  out  [WIDTH-1:0] x BURST  full-width readback of words wr_ptr..wr_ptr+BURST-1.

Behaviour:
- Reset (rst_n=0 at a clk edge): wr_ptr=0, full=0, frame_done=0, all storage words=0. Reset overrides every other input, including in mid-frame.
- Consequently, after reset dout=0 and dout_wr=0.
- Outputs after reset: wr_ready=1.
- wr_ready = !full (combinational). wr_valid is ignored while wr_ready=0.
- Accept = wr_valid && wr_ready. On accept:
  - mem[wr_ptr+k] <= wr_data[k] for k=0..BURST-1.
  - wr_ptr <= wr_ptr+BURST.
- Written data is visible on dout/dout_wr the cycle after accept (1-cycle latency). There is no combinational write-through.
- Last burst (accept with wr_ptr == DEPTH-BURST):
  - wr_ptr wraps to 0.
  - full <= 1.
  - frame_done=1 for exactly that next cycle.
- While full=1:
  - Storage and wr_ptr are frozen.
  - dout is stable for the consumer.
- frame_ack with full=1: full <= 0 next cycle, so wr_ready=1 one cycle after ack. Storage is retained (not cleared); it is overwritten by the next frame.
- frame_ack with full=0 is ignored, including when it coincides with the last-burst accept. In that case full is set and the ack is lost; the consumer must re-ack.
- dout[i] = mem[i][OUT_WIDTH-1:0] (truncation) by default.
- dout_wr[j] = mem[(wr_ptr+j) mod DEPTH]. It never exceeds DEPTH because wr_ptr is BURST-aligned.
- Address arithmetic is PTR_W bits, modulo DEPTH. DEPTH is a power of two in all current instances.

Optional Feature:
- Macro: LAYER_BUF_SAT_EN.
- Defined: dout[i] is mem[i] saturated as signed to the OUT_WIDTH range.
  - Result is +2^(OUT_WIDTH-1)-1 if above it, -2^(OUT_WIDTH-1) if below it, else the low bits.
- Undefined: plain truncation as above.
- dout_wr is unaffected in both cases.

Decomposition:
- Package layer_buf_pkg:
  - Default parameter constants (DEPTH, BURST, WIDTH, OUT_WIDTH).
  - typedef logic signed [WIDTH-1:0] acc_t.
  - typedef logic signed [OUT_WIDTH-1:0] act_t.
  - A function sat_narrow(acc_t) -> act_t.
- One sub-module: layer_buf_ctrl. It holds wr_ptr, full, frame_done and accept logic, and emits the write enable and base address to the storage array in the top.

Test Plan:
- Reset then idle, DEPTH=64, BURST=16 -> wr_ptr=0, full=0, wr_ready=1, all dout=0.
- 4 back-to-back bursts, data = address value -> wr_ptr steps 0,16,32,48,0.
  - frame_done pulses once after the 4th burst.
  - full=1; dout[i]=i.
- While full, drive wr_valid with data 0xFFFF -> wr_ready=0; storage unchanged; wr_ptr stays 0.
- frame_ack while full -> full=0 next cycle, then wr_ready=1.
  - Then drive a burst of 0x5 -> mem[0..15]=0x5; mem[16..63] retain the old values.
- frame_ack in the same cycle as the last-burst accept -> full=1 and stays 1; a second ack clears it.
- Write 36'h0_0004_0001 to mem[0] with LAYER_BUF_SAT_EN defined -> dout[0]=18'h1FFFF.
  - Without the macro -> dout[0]=18'h00001. dout_wr shows the full 36 bits in both builds.
- Assert rst_n=0 after 2 bursts -> next cycle wr_ptr=0, full=0, all dout=0.
